input_buf_scheduler: RTL and testbench

INPUT_BUF_SCHEDULER -- requirements
Module: input_buf_scheduler

---
 rtl/input_buf_scheduler.sv | 119 +++++++++++
 tb/tb_input_buf_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buf_scheduler.sv
// input_buf_scheduler: ping-pong input buffer scheduler pairing DMA fills with buffer-to-SRAM drains.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   job_start, tile_count    start a job of tile_count tiles (ignored while busy)
//   dma_start/_buf_select    fill request and target buffer, held until dma_done
//   b2s_start/_buf_select    drain request and source buffer, held until b2s_done
//   sram_ready               gates the start of each drain
//   input_buffer_rw_select   per buffer, 1 while that buffer is being written by DMA
//   buf_full                 per-buffer full flags
//   fill_count, drain_count  tiles filled / drained in the current job
//   busy, job_done           job in progress / one-cycle completion pulse
module input_buf_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_start,
    input  logic [CNT_W-1:0] tile_count,
    output logic             dma_start,
    output logic             dma_buf_select,
    input  logic             dma_done,
    output logic             b2s_start,
    output logic             b2s_buf_select,
    input  logic             b2s_done,
    input  logic             sram_ready,
    output logic [1:0]       input_buffer_rw_select,
    output logic [1:0]       buf_full,
    output logic [CNT_W-1:0] fill_count,
    output logic [CNT_W-1:0] drain_count,
    output logic             busy,
    output logic             job_done
);
    localparam logic [1:0] F_IDLE = 2'd0, F_WAIT = 2'd1, F_DMA = 2'd2;
    localparam logic [1:0] D_IDLE = 2'd0, D_WAIT = 2'd1, D_XFER = 2'd2;
    logic [1:0]       fst_q, fst_d, dst_q, dst_d, buf_full_q, buf_full_d;
    logic             fill_ptr_q, fill_ptr_d, drain_ptr_q, drain_ptr_d;
    logic             busy_q, busy_d, job_done_q, job_done_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d, drain_cnt_q, drain_cnt_d, tc_q, tc_d;
    always_comb begin
        fst_d       = fst_q;
        dst_d       = dst_q;
        buf_full_d  = buf_full_q;
        fill_ptr_d  = fill_ptr_q;
        drain_ptr_d = drain_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        drain_cnt_d = drain_cnt_q;
        tc_d        = tc_q;
        busy_d      = busy_q;
        job_done_d  = 1'b0;
        if (job_start && !busy_q) begin
            // an empty job completes immediately without ever becoming busy
            fill_cnt_d  = '0;
            drain_cnt_d = '0;
            fill_ptr_d  = 1'b0;
            drain_ptr_d = 1'b0;
            buf_full_d  = '0;
            tc_d        = tile_count;
            busy_d      = tile_count != '0;
            job_done_d  = tile_count == '0;
            fst_d       = tile_count != '0 ? F_WAIT : F_IDLE;
            dst_d       = tile_count != '0 ? D_WAIT : D_IDLE;
        end else begin
            if (fst_q == F_WAIT)
                fst_d = fill_cnt_q == tc_q ? F_IDLE : buf_full_q[fill_ptr_q] ? F_WAIT : F_DMA;
            if (fst_q == F_DMA && dma_done) begin
                fst_d                  = F_WAIT;
                buf_full_d[fill_ptr_q] = 1'b1;
                fill_cnt_d             = fill_cnt_q + 1'b1;
                fill_ptr_d             = !fill_ptr_q;
            end
            if (dst_q == D_WAIT)
                dst_d = drain_cnt_q == tc_q ? D_IDLE : (buf_full_q[drain_ptr_q] && sram_ready) ? D_XFER : D_WAIT;
            // fill and drain always target different buffers when both complete together
            if (dst_q == D_XFER && b2s_done) begin
                buf_full_d[drain_ptr_q] = 1'b0;
                drain_cnt_d             = drain_cnt_q + 1'b1;
                drain_ptr_d             = !drain_ptr_q;
                job_done_d              = drain_cnt_d == tc_q;
                busy_d                  = drain_cnt_d != tc_q;
                dst_d                   = drain_cnt_d == tc_q ? D_IDLE : D_WAIT;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fst_q       <= F_IDLE;
            dst_q       <= D_IDLE;
            buf_full_q  <= '0;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            tc_q        <= '0;
            busy_q      <= 1'b0;
            job_done_q  <= 1'b0;
        end else begin
            fst_q       <= fst_d;
            dst_q       <= dst_d;
            buf_full_q  <= buf_full_d;
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            tc_q        <= tc_d;
            busy_q      <= busy_d;
            job_done_q  <= job_done_d;
        end
    end
    assign dma_start              = fst_q == F_DMA;
    assign dma_buf_select         = dma_start & fill_ptr_q;
    assign b2s_start              = dst_q == D_XFER;
    assign b2s_buf_select         = b2s_start & drain_ptr_q;
    assign input_buffer_rw_select = {dma_start & fill_ptr_q, dma_start & ~fill_ptr_q};
    assign buf_full               = buf_full_q;
    assign fill_count             = fill_cnt_q;
    assign drain_count            = drain_cnt_q;
    assign busy                   = busy_q;
    assign job_done               = job_done_q;
endmodule

// File: tb/tb_input_buf_scheduler.sv
// tb_input_buf_scheduler: directed bench with a tile-count based reference model for input_buf_scheduler.
module tb_input_buf_scheduler;
    logic       clk, rst, job_start, dma_done, b2s_done, sram_ready;
    logic [7:0] tile_count;
    logic       dma_start, dma_buf_select, b2s_start, b2s_buf_select, busy, job_done;
    logic [1:0] input_buffer_rw_select, buf_full;
    logic [7:0] fill_count, drain_count;

    input_buf_scheduler #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .job_start(job_start), .tile_count(tile_count),
        .dma_start(dma_start), .dma_buf_select(dma_buf_select), .dma_done(dma_done),
        .b2s_start(b2s_start), .b2s_buf_select(b2s_buf_select), .b2s_done(b2s_done),
        .sram_ready(sram_ready), .input_buffer_rw_select(input_buffer_rw_select),
        .buf_full(buf_full), .fill_count(fill_count), .drain_count(drain_count),
        .busy(busy), .job_done(job_done)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference model: buffers are used strictly round-robin, so the fill target is
    // fill_count mod 2, the drain source is drain_count mod 2, and occupancy is their difference.
    logic       m_busy, m_dma, m_b2s, m_done;
    logic [7:0] m_fc, m_dc, m_tc, m_occ;
    logic [1:0] e_bf, e_rw;
    assign m_occ = m_fc - m_dc;
    assign e_bf  = m_occ == 0 ? 2'b00 : m_occ == 1 ? (m_dc[0] ? 2'b10 : 2'b01) : 2'b11;
    assign e_rw  = m_dma ? (m_fc[0] ? 2'b10 : 2'b01) : 2'b00;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_dma <= 0; m_b2s <= 0; m_done <= 0;
            m_fc <= 0; m_dc <= 0; m_tc <= 0;
        end else begin
            m_done <= 0;
            if (!m_busy) begin
                if (job_start) begin
                    m_fc <= 0; m_dc <= 0; m_tc <= tile_count; m_dma <= 0; m_b2s <= 0;
                    if (tile_count == 0) m_done <= 1;
                    else m_busy <= 1;
                end
            end else begin
                if (m_dma) begin
                    if (dma_done) begin m_fc <= m_fc + 1; m_dma <= 0; end
                end else if (m_fc < m_tc && m_occ < 2) m_dma <= 1;
                if (m_b2s) begin
                    if (b2s_done) begin
                        m_dc <= m_dc + 1; m_b2s <= 0;
                        if (m_dc + 8'd1 == m_tc) begin m_done <= 1; m_busy <= 0; end
                    end
                end else if (m_occ >= 1 && sram_ready) m_b2s <= 1;
            end
        end
    end

    logic chk_en = 0;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("dma_start", 32'(dma_start), 32'(m_dma));
            chk("dma_buf_select", 32'(dma_buf_select), 32'(m_dma & m_fc[0]));
            chk("b2s_start", 32'(b2s_start), 32'(m_b2s));
            chk("b2s_buf_select", 32'(b2s_buf_select), 32'(m_b2s & m_dc[0]));
            chk("rw_select", 32'(input_buffer_rw_select), 32'(e_rw));
            chk("buf_full", 32'(buf_full), 32'(e_bf));
            chk("fill_count", 32'(fill_count), 32'(m_fc));
            chk("drain_count", 32'(drain_count), 32'(m_dc));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("job_done", 32'(job_done), 32'(m_done));
        end
    end

    // observation monitor for the literal expectations
    bit   fq[$], bq[$];
    bit   pd, pb, stall, act, sim_seen, sim_pend;
    logic [1:0] bf_pre, bf_post;
    int   jd_cnt;
    initial forever begin
        @(negedge clk);
        if (dma_start && !pd) fq.push_back(dma_buf_select);
        if (b2s_start && !pb) bq.push_back(b2s_buf_select);
        pd = dma_start;
        pb = b2s_start;
        if (job_done) jd_cnt++;
        if (busy && buf_full == 2'b11 && !dma_start) stall = 1;
        if (dma_start || b2s_start || busy) act = 1;
        if (sim_pend) begin bf_post = buf_full; sim_pend = 0; end
        if (dma_done && b2s_done) begin bf_pre = buf_full; sim_pend = 1; sim_seen = 1; end
    end

    // done responders with programmable latency, counted from the first cycle the request is seen
    bit resp_en;
    int dma_lat, b2s_lat, dcnt, bcnt;
    initial forever begin
        @(posedge clk); #1;
        if (resp_en) begin
            dma_done = 0;
            b2s_done = 0;
            if (dma_start) begin dcnt++; if (dcnt == dma_lat) begin dma_done = 1; dcnt = 0; end end
            else dcnt = 0;
            if (b2s_start) begin bcnt++; if (bcnt == b2s_lat) begin b2s_done = 1; bcnt = 0; end end
            else bcnt = 0;
        end
    end

    function automatic logic [31:0] pack4(input bit q[$]);
        return q.size() == 4 ? 32'({q[0], q[1], q[2], q[3]}) : 32'hF0;
    endfunction

    task automatic clr();
        fq.delete(); bq.delete();
        jd_cnt = 0; stall = 0; act = 0; sim_seen = 0;
    endtask

    task automatic start(input logic [7:0] tc);
        tile_count = tc;
        job_start  = 1;
        @(posedge clk); #1;
        job_start = 0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!job_done && n < lim);
        chk("job_done_reached", 32'(job_done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; job_start = 0; tile_count = 0; dma_done = 0; b2s_done = 0; sram_ready = 1;
        resp_en = 1; dma_lat = 5; b2s_lat = 3;
        repeat (2) @(negedge clk);
        chk("reset_dma_start", 32'(dma_start), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_buf_full", 32'(buf_full), 0);
        @(posedge clk); #1;
        rst = 0;
        chk_en = 1;

        // single tile
        clr();
        start(1);
        chk("busy_after_start", 32'(busy), 1);
        wait_done(100);
        chk("t1_fill_count", 32'(fill_count), 1);
        chk("t1_drain_count", 32'(drain_count), 1);
        chk("t1_job_done_cnt", 32'(jd_cnt), 1);
        chk("t1_fill_bufs", 32'(fq.size() == 1 && fq[0] == 0), 1);
        chk("t1_drain_bufs", 32'(bq.size() == 1 && bq[0] == 0), 1);
        chk("t1_busy_low", 32'(busy), 0);

        // slow drain forces both buffers full
        clr();
        dma_lat = 2; b2s_lat = 20;
        start(4);
        job_start = 1;
        @(posedge clk); #1;
        job_start = 0;
        wait_done(400);
        chk("t2_stall_seen", 32'(stall), 1);
        chk("t2_fill_order", pack4(fq), 32'b0101);
        chk("t2_drain_order", pack4(bq), 32'b0101);
        chk("t2_counts", 32'({fill_count, drain_count}), 32'h0404);
        chk("t2_job_done_cnt", 32'(jd_cnt), 1);

        // simultaneous completions on different buffers
        clr();
        dma_lat = 3; b2s_lat = 3;
        start(2);
        wait_done(100);
        chk("t3_simultaneous_seen", 32'(sim_seen), 1);
        chk("t3_bf_before", 32'(bf_pre), 32'b01);
        chk("t3_bf_after", 32'(bf_post), 32'b10);
        chk("t3_counts", 32'({fill_count, drain_count}), 32'h0202);

        // empty job
        clr();
        start(0);
        chk("t4_job_done", 32'(job_done), 1);
        chk("t4_counts_cleared", 32'({fill_count, drain_count}), 0);
        repeat (4) @(posedge clk); #1;
        chk("t4_no_activity", 32'(act), 0);
        chk("t4_job_done_cnt", 32'(jd_cnt), 1);

        // reset during the second fill
        clr();
        dma_lat = 6; b2s_lat = 2;
        start(4);
        n = 0;
        while (fq.size() < 2 && n < 100) begin @(negedge clk); n++; end
        chk("t5_second_fill_started", 32'(fq.size()), 2);
        @(posedge clk); #1;
        chk("t5_mid_dma", 32'(dma_start), 1);
        resp_en = 0; dma_done = 0; b2s_done = 0;
        rst = 1;
        #1;
        chk("t5_rst_outputs", 32'({dma_start, dma_buf_select, b2s_start, b2s_buf_select, busy, job_done, input_buffer_rw_select, buf_full}), 0);
        chk("t5_rst_counts", 32'({fill_count, drain_count}), 0);
        @(posedge clk); #1;
        rst = 0;
        dma_done = 1; b2s_done = 1;
        @(posedge clk); #1;
        dma_done = 0; b2s_done = 0;
        @(posedge clk); #1;
        chk("t5_stray_ignored", 32'({dma_start, b2s_start, busy, buf_full, fill_count, drain_count}), 0);
        resp_en = 1;
        start(2);
        wait_done(100);
        chk("t5_rerun_counts", 32'({fill_count, drain_count}), 32'h0202);

        // sram_ready gates the drain start
        clr();
        dma_lat = 2; b2s_lat = 4;
        sram_ready = 0;
        start(1);
        n = 0;
        while (!buf_full[0] && n < 50) begin @(negedge clk); n++; end
        chk("t6_buf0_full", 32'(buf_full), 32'b01);
        n = 0;
        repeat (10) begin @(negedge clk); if (b2s_start) n++; end
        chk("t6_b2s_held_low", 32'(n), 0);
        @(posedge clk); #1;
        sram_ready = 1;
        @(posedge clk); #1;
        chk("t6_b2s_after_ready", 32'(b2s_start), 1);
        sram_ready = 0;
        wait_done(50);
        chk("t6_counts", 32'({fill_count, drain_count}), 32'h0101);
        sram_ready = 1;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
